// File: rtl/mtimer_if.sv
// Bus port of the machine timer: one 32-bit word access per req cycle,
// answered by a registered ack one cycle later.
interface mtimer_if;
    logic        req;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime with a clock prescaler, 64-bit mtimecmp,
// and a registered level interrupt irq_mtimecmp = (mtime >= mtimecmp).
// Word map: 0 = mtime lo, 1 = mtime hi, 2 = mtimecmp lo, 3 = mtimecmp hi.
// Optional build macro MTIMER_SNAPSHOT_EN: a read of mtime lo also latches
// mtime hi into a shadow, and a read of mtime hi returns that shadow so a
// lo-then-hi read pair is consistent across a low-word carry.
module mtimer #(
    parameter int unsigned PRESCALE     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic     clk,
    input  logic     reset,
    mtimer_if.slave  bus,
    output logic     irq_mtimecmp
);
    localparam int unsigned DATA_W   = 32;
    localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

    logic [15:0]       pcnt;
    logic              tick;
    logic [63:0]       mtime;
    logic [63:0]       mtimecmp;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_word;
`ifdef MTIMER_SNAPSHOT_EN
    logic [DATA_W-1:0] mtime_hi_shadow;
`endif

    assign tick  = (pcnt == PCNT_MAX);
    assign wr_en = bus.req & bus.we;
    assign rd_en = bus.req & ~bus.we;

    // Prescaler: counts 0..PRESCALE-1, tick on the last count
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + 16'd1;
    end

    // mtime: a software write to either half wins over (and swallows) the tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            mtime <= '0;
        else if (wr_en && bus.addr == 2'd0)   mtime[31:0]  <= bus.wdata;
        else if (wr_en && bus.addr == 2'd1)   mtime[63:32] <= bus.wdata;
        else if (tick)                        mtime <= mtime + 64'd1;
    end

    // mtimecmp: plain word-writable register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            mtimecmp <= MTIMECMP_RST;
        else if (wr_en && bus.addr == 2'd2)   mtimecmp[31:0]  <= bus.wdata;
        else if (wr_en && bus.addr == 2'd3)   mtimecmp[63:32] <= bus.wdata;
    end

`ifdef MTIMER_SNAPSHOT_EN
    // Shadow of mtime hi, taken on a lo read and kept coherent with hi writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            mtime_hi_shadow <= '0;
        else if (wr_en && bus.addr == 2'd1)   mtime_hi_shadow <= bus.wdata;
        else if (rd_en && bus.addr == 2'd0)   mtime_hi_shadow <= mtime[63:32];
    end
`endif

    // Read mux over the currently registered values
    always_comb begin
        rd_word = '0;
        case (bus.addr)
            2'd0:    rd_word = mtime[31:0];
`ifdef MTIMER_SNAPSHOT_EN
            2'd1:    rd_word = mtime_hi_shadow;
`else
            2'd1:    rd_word = mtime[63:32];
`endif
            2'd2:    rd_word = mtimecmp[31:0];
            default: rd_word = mtimecmp[63:32];
        endcase
    end

    // Bus response: ack follows req by one cycle, rdata holds between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ack   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ack <= bus.req;
            if (rd_en) bus.rdata <= rd_word;
        end
    end

    // Interrupt level from registered values, one cycle behind mtime/mtimecmp
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_mtimecmp <= 1'b0;
        else       irq_mtimecmp <= (mtime >= mtimecmp);
    end
endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: a PRESCALE=1 instance (d1) and a PRESCALE=4 instance (d4).
// Each read pushes its expected word into a per-instance queue; a negedge
// monitor pops on every ack and also checks that ack trails req by one cycle.
module tb_mtimer;
    typedef struct {
        logic        chk;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq1, irq4;
    logic req_d1, req_d4;
    int   total = 0;
    int   bad = 0;
    exp_t q1[$];
    exp_t q4[$];

    mtimer_if b1();
    mtimer_if b4();

    mtimer #(.PRESCALE(1)) d1 (.clk(clk), .reset(reset), .bus(b1.slave), .irq_mtimecmp(irq1));
    mtimer #(.PRESCALE(4)) d4 (.clk(clk), .reset(reset), .bus(b4.slave), .irq_mtimecmp(irq4));

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            req_d1 <= 1'b0;
            req_d4 <= 1'b0;
        end else begin
            req_d1 <= b1.req;
            req_d4 <= b4.req;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (req_d1 || b1.ack) begin
                total++;
                if (b1.ack !== req_d1) begin
                    bad++;
                    $display("FAIL d1_ack_timing: ack=%b required=%b", b1.ack, req_d1);
                end
            end
            if (b1.ack === 1'b1) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d1_unexpected_ack: ack=1 required=no ack");
                end else begin
                    e = q1.pop_front();
                    if (e.chk) begin
                        total++;
                        if (b1.rdata !== e.val) begin
                            bad++;
                            $display("FAIL d1_rdata: got=%h required=%h", b1.rdata, e.val);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (req_d4 || b4.ack) begin
                total++;
                if (b4.ack !== req_d4) begin
                    bad++;
                    $display("FAIL d4_ack_timing: ack=%b required=%b", b4.ack, req_d4);
                end
            end
            if (b4.ack === 1'b1) begin
                if (q4.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d4_unexpected_ack: ack=1 required=no ack");
                end else begin
                    e = q4.pop_front();
                    if (e.chk) begin
                        total++;
                        if (b4.rdata !== e.val) begin
                            bad++;
                            $display("FAIL d4_rdata: got=%h required=%h", b4.rdata, e.val);
                        end
                    end
                end
            end
        end
    end

    task automatic bus_idle();
        b1.req = 1'b0; b1.we = 1'b0; b1.addr = 2'd0; b1.wdata = '0;
        b4.req = 1'b0; b4.we = 1'b0; b4.addr = 2'd0; b4.wdata = '0;
    endtask

    // One access on instance d (1 or 4) for one cycle; req stays up so
    // consecutive calls are back-to-back.
    task automatic issue(input int d, input logic w, input logic [1:0] a,
                         input logic [31:0] wd, input logic [31:0] ev);
        exp_t e;
        e.chk = ~w;
        e.val = ev;
        if (d == 1) begin
            b1.req = 1'b1; b1.we = w; b1.addr = a; b1.wdata = wd;
            q1.push_back(e);
        end else begin
            b4.req = 1'b1; b4.we = w; b4.addr = a; b4.wdata = wd;
            q4.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus_idle();
        @(negedge clk);
        total++; if (b1.ack !== 1'b0)    begin bad++; $display("FAIL rst_ack1: got=%b required=0", b1.ack); end
        total++; if (b1.rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata1: got=%h required=0", b1.rdata); end
        total++; if (irq1 !== 1'b0)      begin bad++; $display("FAIL rst_irq1: got=%b required=0", irq1); end
        total++; if (b4.ack !== 1'b0)    begin bad++; $display("FAIL rst_ack4: got=%b required=0", b4.ack); end
        total++; if (irq4 !== 1'b0)      begin bad++; $display("FAIL rst_irq4: got=%b required=0", irq4); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        issue(1, 1'b0, 2'd0, 32'd0, 32'd10);
        bus_idle();
        @(negedge clk);
        total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL idle_irq1: got=%b required=0", irq1); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (40) @(negedge clk);
        issue(4, 1'b0, 2'd0, 32'd0, 32'd10);
        issue(4, 1'b0, 2'd0, 32'd0, 32'd10);
        issue(4, 1'b0, 2'd0, 32'd0, 32'd10);
        issue(4, 1'b0, 2'd0, 32'd0, 32'd10);
        issue(4, 1'b0, 2'd0, 32'd0, 32'd11);
        issue(4, 1'b0, 2'd1, 32'd0, 32'd0);
        bus_idle();
        @(negedge clk);
    endtask

    task automatic test_irq();
        do_reset();
        issue(1, 1'b1, 2'd3, 32'd0, 32'd0);
        issue(1, 1'b1, 2'd2, 32'd20, 32'd0);
        bus_idle();
        repeat (18) @(negedge clk);
        total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL irq_before: got=%b required=0", irq1); end
        @(negedge clk);
        total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL irq_rise: got=%b required=1", irq1); end
        issue(1, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'd0);
        bus_idle();
        total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL irq_lag: got=%b required=1", irq1); end
        @(negedge clk);
        total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL irq_fall: got=%b required=0", irq1); end
    endtask

    task automatic test_carry();
        do_reset();
        issue(1, 1'b1, 2'd0, 32'hFFFF_FFFE, 32'd0);
        issue(1, 1'b1, 2'd1, 32'd0, 32'd0);
        issue(1, 1'b0, 2'd0, 32'd0, 32'hFFFF_FFFE);
        issue(1, 1'b0, 2'd1, 32'd0, 32'd0);
        issue(1, 1'b0, 2'd0, 32'd0, 32'd0);
        issue(1, 1'b0, 2'd1, 32'd0, 32'd1);
        bus_idle();
        @(negedge clk);
    endtask

    task automatic test_write_tick();
        do_reset();
        repeat (3) @(negedge clk);
        issue(1, 1'b1, 2'd0, 32'd5, 32'd0);
        issue(1, 1'b0, 2'd0, 32'd0, 32'd5);
        issue(1, 1'b1, 2'd2, 32'd100, 32'd0);
        issue(1, 1'b0, 2'd0, 32'd0, 32'd7);
        issue(1, 1'b0, 2'd2, 32'd0, 32'd100);
        issue(1, 1'b0, 2'd3, 32'd0, 32'hFFFF_FFFF);
        bus_idle();
    endtask

    task automatic test_reset_mid();
        b1.req = 1'b1; b1.we = 1'b0; b1.addr = 2'd0;
        #2 reset = 1'b1;
        #1;
        total++; if (b1.ack !== 1'b0)    begin bad++; $display("FAIL mid_ack: got=%b required=0", b1.ack); end
        total++; if (b1.rdata !== 32'd0) begin bad++; $display("FAIL mid_rdata: got=%h required=0", b1.rdata); end
        total++; if (irq1 !== 1'b0)      begin bad++; $display("FAIL mid_irq: got=%b required=0", irq1); end
        @(negedge clk);
        total++; if (b1.ack !== 1'b0)    begin bad++; $display("FAIL mid_dropped_ack: got=%b required=0", b1.ack); end
        bus_idle();
        reset = 1'b0;
        issue(1, 1'b0, 2'd2, 32'd0, 32'hFFFF_FFFF);
        issue(1, 1'b0, 2'd3, 32'd0, 32'hFFFF_FFFF);
        bus_idle();
        @(negedge clk);
        total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL mid_irq_after: got=%b required=0", irq1); end
    endtask

    task automatic test_snapshot();
        logic [31:0] hi_exp;
`ifdef MTIMER_SNAPSHOT_EN
        hi_exp = 32'd0;
`else
        hi_exp = 32'd1;
`endif
        do_reset();
        issue(1, 1'b1, 2'd1, 32'd0, 32'd0);
        issue(1, 1'b1, 2'd0, 32'hFFFF_FFFD, 32'd0);
        bus_idle();
        repeat (2) @(negedge clk);
        issue(1, 1'b0, 2'd0, 32'd0, 32'hFFFF_FFFF);
        bus_idle();
        repeat (3) @(negedge clk);
        issue(1, 1'b0, 2'd1, 32'd0, hi_exp);
        bus_idle();
        @(negedge clk);
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_back_to_back();
        test_irq();
        test_carry();
        test_write_tick();
        test_reset_mid();
        test_snapshot();
        repeat (2) @(negedge clk);
        total++; if (q1.size() != 0) begin bad++; $display("FAIL d1_missing_acks: pending=%0d required=0", q1.size()); end
        total++; if (q4.size() != 0) begin bad++; $display("FAIL d4_missing_acks: pending=%0d required=0", q4.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t required=finish before 200000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
